// File: rtl/ru_pkg.sv
// ----------------------------------------------------------------------------
// ru_pkg
// Shared constants and types for the integer register unit.
//   XLEN_C     : default data width of a register / data port
//   REG_IDX_W  : width of every register index port
//   REG_ZERO   : index of the hard-wired zero register x0
//   REG_SP     : index of the stack pointer x2
//   SP_INIT_C  : default reset value of x2
// ----------------------------------------------------------------------------
package ru_pkg;

    localparam int XLEN_C    = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN_C-1:0]    xword_t;

    localparam reg_idx_t REG_ZERO  = 5'd0;
    localparam reg_idx_t REG_SP    = 5'd2;
    localparam xword_t   SP_INIT_C = 32'h0000_03FC;

endpackage

// File: rtl/ru_read_port.sv
// ----------------------------------------------------------------------------
// ru_read_port
// One combinational read path of the register unit: array select, x0
// zero-force and (optionally) write-through bypass from the WB write port.
//   i_regs_flat : flattened register array, entry k at [k*XLEN +: XLEN]
//   i_rs        : read index
//   i_wr_en     : WB write enable (raw RUWr)
//   i_wr_idx    : WB destination index
//   i_wr_data   : WB write data
//   o_rdata     : read data
// ----------------------------------------------------------------------------
module ru_read_port
    import ru_pkg::*;
#(
    parameter int XLEN   = XLEN_C,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
)(
    input  logic [NREGS*XLEN-1:0] i_regs_flat,
    input  logic [REG_IDX_W-1:0]  i_rs,
    input  logic                  i_wr_en,
    input  logic [REG_IDX_W-1:0]  i_wr_idx,
    input  logic [XLEN-1:0]       i_wr_data,
    output logic [XLEN-1:0]       o_rdata
);

    logic [XLEN-1:0] w_array_data;
    logic            w_bypass_hit;

    // x0 and indices beyond the implemented register count read as zero.
    always_comb begin
        // NOTE: assign a default before any conditional assignment in
        // always_comb, otherwise an unassigned path infers a latch.
        w_array_data = '0;
        if (i_rs != REG_ZERO && int'(i_rs) < NREGS)
            w_array_data = i_regs_flat[int'(i_rs)*XLEN +: XLEN];
    end

    // Write-first forwarding: the value being committed this edge is shown
    // to the ID stage in the same cycle. Writes that would be dropped
    // (x0, out-of-range index) never forward.
    assign w_bypass_hit = (BYPASS != 0) && i_wr_en && (i_wr_idx == i_rs) &&
                          (i_wr_idx != REG_ZERO) && (int'(i_wr_idx) < NREGS);

    assign o_rdata = w_bypass_hit ? i_wr_data : w_array_data;

endmodule

// File: rtl/register_unit.sv
// ----------------------------------------------------------------------------
// register_unit
// 32-entry integer register file for the segmented RISC-V datapath.
// One synchronous write port fed from the WB stage, two combinational read
// ports for ID (optionally write-through bypassed) and one debug read port
// that always shows the committed array contents.
//   clk       : system clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   RUWr      : write enable from WB control
//   rd        : destination register index
//   RUDataWr  : write data from the writeback select
//   rs1, rs2  : ID-stage source indices
//   RURs1/2   : read data for rs1 / rs2
//   dbg_addr  : debug read index
//   dbg_data  : debug read data (never bypassed)
// ----------------------------------------------------------------------------
module register_unit
    import ru_pkg::*;
#(
    parameter int              XLEN    = XLEN_C,
    parameter int              NREGS   = 32,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_C),
    parameter int              BYPASS  = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RUWr,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [XLEN-1:0]      RUDataWr,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]      RURs1,
    output logic [XLEN-1:0]      RURs2,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [XLEN-1:0]      dbg_data
);

    // x0 has no storage; entries 1..NREGS-1 only.
    logic [XLEN-1:0]       r_regs [1:NREGS-1];
    logic [NREGS*XLEN-1:0] w_regs_flat;
    logic                  w_wr_en;

    // Writes to x0 or to indices past NREGS are dropped.
    assign w_wr_en = RUWr && (rd != REG_ZERO) && (int'(rd) < NREGS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the array is built from flops and every entry is reset,
            // so no read can ever return an undefined value; a RAM macro
            // without reset could not give that guarantee.
            for (int i = 1; i < NREGS; i++)
                r_regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // reader in the same edge sees the pre-edge value.
            for (int i = 1; i < NREGS; i++)
                if (w_wr_en && int'(rd) == i)
                    r_regs[i] <= RUDataWr;
        end
    end

    // Flatten the array for the read-port sub-modules; slot 0 is constant 0.
    always_comb begin
        w_regs_flat = '0;
        for (int i = 1; i < NREGS; i++)
            w_regs_flat[i*XLEN +: XLEN] = r_regs[i];
    end

    ru_read_port #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_rd_port1 (
        .i_regs_flat (w_regs_flat),
        .i_rs        (rs1),
        .i_wr_en     (RUWr),
        .i_wr_idx    (rd),
        .i_wr_data   (RUDataWr),
        .o_rdata     (RURs1)
    );

    ru_read_port #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_rd_port2 (
        .i_regs_flat (w_regs_flat),
        .i_rs        (rs2),
        .i_wr_en     (RUWr),
        .i_wr_idx    (rd),
        .i_wr_data   (RUDataWr),
        .o_rdata     (RURs2)
    );

    // Debug port shows committed state only, hence no bypass path.
    always_comb begin
        dbg_data = '0;
        if (dbg_addr != REG_ZERO && int'(dbg_addr) < NREGS)
            dbg_data = w_regs_flat[int'(dbg_addr)*XLEN +: XLEN];
    end

endmodule
